// File: rtl/fifo_pac_overflow_sc.sv
// Single-clock FIFO for the PAC overflow path. It has a parametrised
// depth, width and read mode, an exact fill level, an almost-full flag,
// and sticky overflow/underflow flags with a saturating count of
// rejected writes.
module fifo_pac_overflow_sc #(
   parameter int unsigned DATA_W    = 512,
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned AFULL_TH  = (1 << ADDR_W) - 4,
   parameter bit          SHOWAHEAD = 1'b1,
   parameter int unsigned OVF_W     = 16
) (
   input  logic              clk,
   input  logic              aclr,
   input  logic [DATA_W-1:0] data,
   input  logic              wrreq,
   input  logic              rdreq,
   input  logic              clr_status,
   output logic [DATA_W-1:0] q,
   output logic              rdempty,
   output logic              wrfull,
   output logic              almost_full,
   output logic [ADDR_W:0]   usedw,
   output logic              overflow,
   output logic              underflow,
   output logic [OVF_W-1:0]  ovf_count
);

   localparam int unsigned     DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_TH);
   localparam logic [OVF_W-1:0] OVF_MAX = '1;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   usedw_q, usedw_d;
   logic              rdempty_q, rdempty_d;
   logic              wrfull_q, wrfull_d;
   logic              afull_q, afull_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic [OVF_W-1:0]  ovf_cnt_q, ovf_cnt_d;
   logic [DATA_W-1:0] q_q, q_d;

   logic wr_acc, rd_acc, wr_rej, rd_rej;

   // Next-state: acceptance, pointers, occupancy, flags, status and read data
   always_comb begin
      wr_acc    = wrreq & ~wrfull_q;
      rd_acc    = rdreq & ~rdempty_q;
      wr_rej    = wrreq & wrfull_q;
      rd_rej    = rdreq & rdempty_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      usedw_d   = usedw_q;
      ovf_d     = ovf_q;
      udf_d     = udf_q;
      ovf_cnt_d = ovf_cnt_q;
      q_d       = q_q;

      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);

      case ({wr_acc, rd_acc})
         2'b10:   usedw_d = usedw_q + (ADDR_W+1)'(1);
         2'b01:   usedw_d = usedw_q - (ADDR_W+1)'(1);
         default: usedw_d = usedw_q;
      endcase

      // Flags come from the next occupancy so they are registered and glitch-free
      rdempty_d = (usedw_d == '0);
      wrfull_d  = (usedw_d == DEPTH_C);
      afull_d   = (usedw_d >= AFULL_C);

      // A clear in the same cycle as a new event gives the event priority
      if (clr_status) begin
         ovf_d     = 1'b0;
         udf_d     = 1'b0;
         ovf_cnt_d = '0;
      end
      if (wr_rej) begin
         ovf_d = 1'b1;
         if (clr_status)              ovf_cnt_d = OVF_W'(1);
         else if (ovf_cnt_q != OVF_MAX) ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
      end
      if (rd_rej) udf_d = 1'b1;

      if (SHOWAHEAD) begin
         // Present the head word. A word written into the slot that becomes
         // the head is bypassed, because mem is updated only at this edge.
         if (usedw_d != '0) begin
            if (wr_acc && (wr_ptr_q == rd_ptr_d)) q_d = data;
            else                                  q_d = mem[rd_ptr_d];
         end
      end else begin
         if (rd_acc) q_d = mem[rd_ptr_q];
      end
   end

   // Storage array, not reset
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr_q] <= data;
   end

   // State and output registers
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         usedw_q   <= '0;
         rdempty_q <= 1'b1;
         wrfull_q  <= 1'b0;
         afull_q   <= 1'b0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         ovf_cnt_q <= '0;
         q_q       <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         usedw_q   <= usedw_d;
         rdempty_q <= rdempty_d;
         wrfull_q  <= wrfull_d;
         afull_q   <= afull_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
         ovf_cnt_q <= ovf_cnt_d;
         q_q       <= q_d;
      end
   end

   assign q           = q_q;
   assign rdempty     = rdempty_q;
   assign wrfull      = wrfull_q;
   assign almost_full = afull_q;
   assign usedw       = usedw_q;
   assign overflow    = ovf_q;
   assign underflow   = udf_q;
   assign ovf_count   = ovf_cnt_q;

endmodule

// File: tb/tb_fifo_pac_overflow_sc.sv
// Bench for fifo_pac_overflow_sc. Two instances receive the same stimulus:
// a show-ahead one with a 4-bit overflow counter and a registered-read one
// with a 16-bit counter. A reference queue and occupancy/status model
// supply every expected value.
module tb_fifo_pac_overflow_sc;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 6;
   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned AFTH  = DEPTH - 4;

   logic          clk = 1'b0;
   logic          aclr;
   logic [DW-1:0] data;
   logic          wrreq, rdreq, clr_status;

   logic [DW-1:0] q_a, q_b;
   logic          rdempty_a, wrfull_a, afull_a, ovf_a, udf_a;
   logic          rdempty_b, wrfull_b, afull_b, ovf_b, udf_b;
   logic [AW:0]   usedw_a, usedw_b;
   logic [3:0]    cnt_a;
   logic [15:0]   cnt_b;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model
   logic [DW-1:0] sb [$];
   int mcnt, mca, mcb;
   bit movf, mudf;

   always #5 clk = ~clk;

   fifo_pac_overflow_sc #(
      .DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AFTH), .SHOWAHEAD(1'b1), .OVF_W(4)
   ) u_dut_a (
      .clk(clk), .aclr(aclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
      .clr_status(clr_status), .q(q_a), .rdempty(rdempty_a), .wrfull(wrfull_a),
      .almost_full(afull_a), .usedw(usedw_a), .overflow(ovf_a),
      .underflow(udf_a), .ovf_count(cnt_a)
   );

   fifo_pac_overflow_sc #(
      .DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AFTH), .SHOWAHEAD(1'b0), .OVF_W(16)
   ) u_dut_b (
      .clk(clk), .aclr(aclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
      .clr_status(clr_status), .q(q_b), .rdempty(rdempty_b), .wrfull(wrfull_b),
      .almost_full(afull_b), .usedw(usedw_b), .overflow(ovf_b),
      .underflow(udf_b), .ovf_count(cnt_b)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_flags();
      check_eq("usedw_a",   64'(usedw_a),   64'(mcnt));
      check_eq("rdempty_a", 64'(rdempty_a), 64'(mcnt == 0));
      check_eq("wrfull_a",  64'(wrfull_a),  64'(mcnt == DEPTH));
      check_eq("afull_a",   64'(afull_a),   64'(mcnt >= AFTH));
      check_eq("ovf_a",     64'(ovf_a),     64'(movf));
      check_eq("udf_a",     64'(udf_a),     64'(mudf));
      check_eq("cnt_a",     64'(cnt_a),     64'(mca));
      check_eq("usedw_b",   64'(usedw_b),   64'(mcnt));
      check_eq("rdempty_b", 64'(rdempty_b), 64'(mcnt == 0));
      check_eq("wrfull_b",  64'(wrfull_b),  64'(mcnt == DEPTH));
      check_eq("ovf_b",     64'(ovf_b),     64'(movf));
      check_eq("cnt_b",     64'(cnt_b),     64'(mcb));
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_q_a",     64'(q_a),       64'(0));
      check_eq("rst_q_b",     64'(q_b),       64'(0));
      check_eq("rst_rdempty", 64'(rdempty_a), 64'(1));
      check_eq("rst_wrfull",  64'(wrfull_a),  64'(0));
      check_eq("rst_afull",   64'(afull_a),   64'(0));
      check_eq("rst_usedw",   64'(usedw_a),   64'(0));
      check_eq("rst_ovf",     64'(ovf_a),     64'(0));
      check_eq("rst_udf",     64'(udf_a),     64'(0));
      check_eq("rst_cnt_a",   64'(cnt_a),     64'(0));
      check_eq("rst_cnt_b",   64'(cnt_b),     64'(0));
      check_eq("rst_usedw_b", 64'(usedw_b),   64'(0));
   endtask

   // One clock of stimulus; called with time just after an active edge
   task automatic step(input bit wr, input bit rd, input logic [DW-1:0] d, input bit clr);
      logic [DW-1:0] exp;
      bit wa, ra;
      wrreq      = wr;
      rdreq      = rd;
      data       = d;
      clr_status = clr;
      wa  = wr && (mcnt != DEPTH);
      ra  = rd && (mcnt != 0);
      exp = '0;
      if (ra) begin
         exp = sb.pop_front();
         check_eq("q_fwft", 64'(q_a), 64'(exp));
      end
      if (wa) sb.push_back(d);
      if (wa && !ra) mcnt++;
      else if (ra && !wa) mcnt--;
      if (clr) begin
         movf = 1'b0; mudf = 1'b0; mca = 0; mcb = 0;
      end
      if (wr && !wa) begin
         movf = 1'b1;
         if (mca < 15)    mca++;
         if (mcb < 65535) mcb++;
      end
      if (rd && !ra) mudf = 1'b1;
      @(posedge clk);
      #1;
      wrreq      = 1'b0;
      rdreq      = 1'b0;
      clr_status = 1'b0;
      if (ra) check_eq("q_reg", 64'(q_b), 64'(exp));
      check_flags();
   endtask

   task automatic model_reset();
      sb.delete();
      mcnt = 0; mca = 0; mcb = 0; movf = 1'b0; mudf = 1'b0;
   endtask

   task automatic fill(input int base);
      while (mcnt < int'(DEPTH)) step(1'b1, 1'b0, DW'(base + mcnt), 1'b0);
   endtask

   task automatic drain();
      while (mcnt > 0) step(1'b0, 1'b1, '0, 1'b0);
   endtask

   initial begin
      model_reset();
      aclr = 1'b1; data = '0; wrreq = 1'b0; rdreq = 1'b0; clr_status = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      aclr = 1'b0;

      // Underflow on empty, then simultaneous read and write while empty
      step(1'b0, 1'b1, '0, 1'b0);
      step(1'b1, 1'b1, 32'h1234_5678, 1'b0);
      step(1'b0, 1'b1, '0, 1'b0);

      // Asynchronous reset mid-traffic at usedw=5
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(32'hC0 + i), 1'b0);
      #3;
      aclr = 1'b1;
      #1;
      model_reset();
      check_reset_outputs();
      @(posedge clk);
      #1;
      check_reset_outputs();
      aclr = 1'b0;
      step(1'b1, 1'b0, 32'hA5A5_A5A5, 1'b0);
      step(1'b0, 1'b1, '0, 1'b0);

      // Fill and drain three times to wrap the pointers
      for (int r = 0; r < 3; r++) begin
         fill(r * 64);
         drain();
      end

      // Overflow accounting while full
      fill(32'h1000);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'hDEAD_0000 + DW'(i), 1'b0);
      step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1);
      drain();

      // Counter saturation and clear coinciding with a rejected write
      fill(32'h2000);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'hBAD0_0000 + DW'(i), 1'b0);
      step(1'b1, 1'b0, 32'hBAD1_0000, 1'b1);
      drain();

      // Random simultaneous traffic against the reference model
      for (int i = 0; i < 10000; i++) begin
         int wp;
         wp = (i < 5000) ? 60 : 40;
         step(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < 100 - wp),
              DW'($urandom), ($urandom_range(0, 63) == 0));
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fifo_pac_overflow_sc.md
# fifo_pac_overflow_sc

Single-clock, parametrised successor of the PAC overflow FIFO. It buffers wide data words between a producer and a consumer in the same clock domain. It adds a configurable depth, width and read mode, an almost-full threshold, an exact fill level, and overflow/underflow accounting. It sits on the PAC overflow path, where dropped writes must be counted and reported rather than silently lost.

## Interface
- DATA_W, 512, data word width in bits
- ADDR_W, 6, log2 of depth; DEPTH = 2**ADDR_W entries
- AFULL_TH, DEPTH-4, almost_full asserts when usedw >= AFULL_TH (legal range 1..DEPTH)
- SHOWAHEAD, 1, 1 = first-word-fall-through; 0 = registered read (q updates after rdreq)
- OVF_W, 16, width of saturating overflow event counter

- clk  in  1  positive-edge clock for all logic
- aclr  in  1  asynchronous, active-high reset
- data  in  DATA_W  write data
- wrreq  in  1  write request
- rdreq  in  1  read request
- clr_status  in  1  synchronous clear of overflow, underflow, ovf_count
- q  out  DATA_W  read data
- rdempty  out  1  FIFO empty; a read is valid only when low
- wrfull  out  1  FIFO full; a write is valid only when low
- almost_full  out  1  usedw >= AFULL_TH
- usedw  out  ADDR_W+1  number of stored words, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty
- ovf_count  out  OVF_W  number of rejected writes, saturates at all-ones

## Operation
- Storage: DEPTH-entry array with ADDR_W-bit write and read pointers. Pointers wrap modulo DEPTH. usedw is an (ADDR_W+1)-bit occupancy counter.
- Write accepted = wrreq & !wrfull: the word is stored at wr_ptr and wr_ptr increments.
- Read accepted = rdreq & !rdempty: rd_ptr increments.
- Flag derivation:
  - rdempty = (usedw == 0)
  - wrfull = (usedw == DEPTH)
  - almost_full = (usedw >= AFULL_TH)
  - All flags are registered from the next-state usedw, so they are glitch-free.
- Simultaneous read and write:
  - Both accepted (neither full nor empty): usedw is unchanged and both pointers advance.
  - When full: the write is rejected even if rdreq is accepted in the same cycle. The overflow event is counted and usedw goes to DEPTH-1.
  - When empty: the read is rejected and underflow sets. The write is accepted and usedw goes to 1.
- Rejected write (wrreq & wrfull):
  - Data is discarded and memory and pointers are unchanged.
  - overflow sets.
  - ovf_count increments, saturating at 2**OVF_W-1.
- Rejected read (rdreq & rdempty): underflow sets; q, pointers and usedw are unchanged.
- clr_status:
  - Clears overflow, underflow and ovf_count on the next edge.
  - If a rejected write occurs in the same cycle, the new event wins: overflow=1, ovf_count=1.
  - If a rejected read occurs in the same cycle, underflow=1.
- SHOWAHEAD=1: q continuously presents mem[rd_ptr] while !rdempty. While rdempty=1, q holds its last value.
- SHOWAHEAD=0: on an accepted read, q loads mem[rd_ptr] at that edge. Otherwise q holds.
- Reset: aclr clears pointers and all status; memory contents are not cleared.

## Timing
- Reset values while aclr=1 and after release:
  - q=0, rdempty=1, wrfull=0, almost_full=0, usedw=0
  - overflow=0, underflow=0, ovf_count=0
- aclr asserted mid-operation: all outputs go to reset values asynchronously and in-flight requests are lost. The first request is accepted on the first clk edge with aclr low.
- Write latency: a write accepted at edge N updates usedw, wrfull and almost_full after edge N. rdempty falls after edge N.
  - SHOWAHEAD=1: the word is valid on q in cycle N+1 (write-to-read latency of 1 cycle).
- Read latency:
  - SHOWAHEAD=1: q is valid in the same cycle that rdempty=0; rdreq acknowledges the word and q advances after the edge.
  - SHOWAHEAD=0: q is valid in the cycle after the accepted rdreq edge.
- Status flags update at the edge of the event and are visible in the following cycle.
- No combinational path from wrreq or rdreq to any output.

## Test plan
- Reset/idle: assert aclr mid-traffic at usedw=5 -> immediately q=0, rdempty=1, usedw=0, all status 0; after release, write 0xA5.. then rdempty=0 one cycle later.
- Fill/drain ordering (ADDR_W=6): write 64 incrementing words -> wrfull=1 at usedw=64, almost_full=1 from usedw=60; read 64 -> data 0..63 in order, rdempty=1 after the last read; repeat 3x to exercise pointer wrap.
- Overflow accounting: while full, assert wrreq for 10 cycles -> ovf_count=10, overflow=1, contents unchanged; full + rdreq + wrreq in one cycle -> usedw=63, ovf_count=11; pulse clr_status -> overflow=0, ovf_count=0.
- Counter saturation (OVF_W=4): 20 rejected writes -> ovf_count=15, held; clr_status coincident with a rejected write -> ovf_count=1, overflow=1.
- Underflow/empty corner: rdreq while empty -> underflow=1, usedw=0; rdreq+wrreq while empty -> usedw=1, underflow=1, written word read back correctly.
- Mode check: repeat fill/drain with SHOWAHEAD=0 -> each q appears one cycle after its accepted rdreq, same data order; random simultaneous read/write for 10k cycles vs reference queue model -> zero mismatches, usedw always 0..DEPTH.
